// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: FSM states, forwarding
// selects, regWrite bit positions and the per-cycle pipeline control bundle.
package hazard_ctrl_pkg;

    localparam logic [1:0] ST_RUN        = 2'd0;
    localparam logic [1:0] ST_LOAD_STALL = 2'd1;
    localparam logic [1:0] ST_FLUSH      = 2'd2;
    localparam logic [1:0] ST_MEM_WAIT   = 2'd3;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    localparam int RW_DEST = 0;
    localparam int RW_R0   = 1;

    localparam logic [3:0] R0_IDX = 4'h0;

    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic ifid_flush;
        logic idex_bubble;
        logic pipe_hold;
    } ctrl_t;

    localparam ctrl_t CTRL_RUN    = ctrl_t'(5'b11000);
    localparam ctrl_t CTRL_FLUSH  = ctrl_t'(5'b11110);
    localparam ctrl_t CTRL_STALL  = ctrl_t'(5'b00010);
    localparam ctrl_t CTRL_FREEZE = ctrl_t'(5'b00001);

    // A producer feeds a source through its normal destination or its R0 result path.
    function automatic logic producer_match(input logic [3:0] src,
                                            input logic [3:0] dest,
                                            input logic [1:0] rw);
        return (rw[RW_DEST] && (dest == src)) || (rw[RW_R0] && (src == R0_IDX));
    endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_unit.sv
// Operand forwarding comparator for one source register; EX/MEM is the
// youngest producer and therefore wins over MEM/WB.
module hazard_ctrl_fwd_unit
    import hazard_ctrl_pkg::*;
(
    input  logic [3:0] src_i,
    input  logic       use_i,
    input  logic [3:0] mem_dest_i,
    input  logic [1:0] mem_rw_i,
    input  logic [3:0] wb_dest_i,
    input  logic [1:0] wb_rw_i,
    output logic [1:0] sel_o
);

    always_comb begin
        sel_o = FWD_RF;
        if (use_i) begin
            if (producer_match(src_i, mem_dest_i, mem_rw_i)) begin
                sel_o = FWD_EXMEM;
            end else if (producer_match(src_i, wb_dest_i, wb_rw_i)) begin
                sel_o = FWD_MEMWB;
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller: memory-wait freeze, taken-branch flush,
// load-use bubble, operand forwarding and a saturating stall-cycle counter.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [3:0]       id_rs1_i,
    input  logic [3:0]       id_rs2_i,
    input  logic             id_use1_i,
    input  logic             id_use2_i,
    input  logic [3:0]       ex_dest_i,
    input  logic [1:0]       ex_regWrite_i,
    input  logic             ex_memRead_i,
    input  logic [3:0]       mem_dest_i,
    input  logic [1:0]       mem_regWrite_i,
    input  logic [3:0]       wb_dest_i,
    input  logic [1:0]       wb_regWrite_i,
    input  logic             branch_taken_i,
    input  logic             mem_req_i,
    input  logic             mem_ready_i,
    output logic             pc_write_o,
    output logic             ifid_write_o,
    output logic             ifid_flush_o,
    output logic             idex_bubble_o,
    output logic             pipe_hold_o,
    output logic [1:0]       fwdA_o,
    output logic [1:0]       fwdB_o,
    output logic             mem_err_o,
    output logic [CNT_W-1:0] stall_cycles_o,
    output logic [1:0]       state_o
);

    localparam int TMR_W = $clog2(MEM_TIMEOUT);
    // The first wait cycle is spent in RUN, so MEM_WAIT holds MEM_TIMEOUT-1 cycles at most.
    localparam logic [TMR_W-1:0] WAIT_LAST = TMR_W'(MEM_TIMEOUT - 2);

    logic [1:0]       state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] stall_q, stall_d;

    ctrl_t ctrl, ctrl_out;
    logic  mem_wait, load_use, branch_ok;
    logic  [1:0] fwd_a, fwd_b;
    logic  unused_ex_rw_r0;

    assign unused_ex_rw_r0 = ex_regWrite_i[RW_R0];

    hazard_ctrl_fwd_unit u_fwd_a (
        .src_i      (id_rs1_i),
        .use_i      (id_use1_i),
        .mem_dest_i (mem_dest_i),
        .mem_rw_i   (mem_regWrite_i),
        .wb_dest_i  (wb_dest_i),
        .wb_rw_i    (wb_regWrite_i),
        .sel_o      (fwd_a)
    );

    hazard_ctrl_fwd_unit u_fwd_b (
        .src_i      (id_rs2_i),
        .use_i      (id_use2_i),
        .mem_dest_i (mem_dest_i),
        .mem_rw_i   (mem_regWrite_i),
        .wb_dest_i  (wb_dest_i),
        .wb_rw_i    (wb_regWrite_i),
        .sel_o      (fwd_b)
    );

    always_comb begin
        // The cycle after an abandoned access lets the pipeline move on instead of re-waiting.
        mem_wait  = mem_req_i && !mem_ready_i && !err_q;
        load_use  = ex_memRead_i && ex_regWrite_i[RW_DEST] &&
                    ((id_use1_i && (ex_dest_i == id_rs1_i)) ||
                     (id_use2_i && (ex_dest_i == id_rs2_i)));
        branch_ok = branch_taken_i && ((state_q == ST_RUN) || (state_q == ST_LOAD_STALL));

        ctrl    = CTRL_RUN;
        state_d = ST_RUN;
        err_d   = 1'b0;

        if (mem_wait) begin
            ctrl = CTRL_FREEZE;
            if ((state_q == ST_MEM_WAIT) && (tmr_q == WAIT_LAST)) begin
                err_d = 1'b1;
            end else begin
                state_d = ST_MEM_WAIT;
            end
        end else if (branch_ok) begin
            ctrl    = CTRL_FLUSH;
            state_d = ST_FLUSH;
        end else if (load_use) begin
            ctrl    = CTRL_STALL;
            state_d = ST_LOAD_STALL;
        end

        tmr_d   = ((state_q == ST_MEM_WAIT) && (state_d == ST_MEM_WAIT)) ? tmr_q + 1'b1 : '0;
        stall_d = (!ctrl.pc_write && (stall_q != '1)) ? stall_q + 1'b1 : stall_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_RUN;
            tmr_q   <= '0;
            err_q   <= 1'b0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            err_q   <= err_d;
            stall_q <= stall_d;
        end
    end

    // While reset is low the outputs show reset values even if hazard inputs are live.
    assign ctrl_out       = rst_ni ? ctrl : CTRL_RUN;
    assign pc_write_o     = ctrl_out.pc_write;
    assign ifid_write_o   = ctrl_out.ifid_write;
    assign ifid_flush_o   = ctrl_out.ifid_flush;
    assign idex_bubble_o  = ctrl_out.idex_bubble;
    assign pipe_hold_o    = ctrl_out.pipe_hold;
    assign fwdA_o         = rst_ni ? fwd_a : FWD_RF;
    assign fwdB_o         = rst_ni ? fwd_b : FWD_RF;
    assign mem_err_o      = err_q;
    assign stall_cycles_o = stall_q;
    assign state_o        = state_q;

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall controller for the 16-bit, 4-stage-register CPU pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB). Each cycle it detects load-use, taken-branch and data-memory-wait hazards. It drives the PC and pipeline-register write enables, bubbles and flushes, and selects operand forwarding from the EX/MEM and MEM/WB stages. It also keeps a saturating stall-cycle counter for performance debug.

## Interface
- MEM_TIMEOUT, 15: maximum cycles in MEM_WAIT before the wait is abandoned.
- CNT_W, 16: width of the stall counter.

- clk  in  1  system clock; the state register updates on the rising edge.
- reset  in  1  asynchronous, active-low; clears all state.
- id_rs1, id_rs2  in  4  IF/ID source register numbers.
- id_use1, id_use2  in  1  the corresponding source is actually read.
- ex_dest  in  4  ID/EX destination register.
- ex_regWrite  in  2  ID/EX write enables. Bit0 writes the destination register; bit1 writes R0 (R0result path).
- ex_memRead  in  1  ID/EX instruction is a load.
- mem_dest  in  4  EX/MEM destination register.
- mem_regWrite  in  2  EX/MEM write enables.
- wb_dest  in  4  MEM/WB destination register (Fwriteback).
- wb_regWrite  in  2  MEM/WB write enables (CregWrite).
- branch_taken  in  1  EX stage resolved a taken branch.
- mem_req  in  1  EX/MEM instruction accesses data memory.
- mem_ready  in  1  data memory completes the access this cycle.
- pc_write  out  1  PC may advance.
- ifid_write  out  1  IF/ID may load.
- ifid_flush  out  1  IF/ID loads a NOP.
- idex_bubble  out  1  ID/EX loads a NOP (control signals zeroed).
- pipe_hold  out  1  ID/EX, EX/MEM and MEM/WB hold their contents.
- fwdA, fwdB  out  2  operand select: 00 register file, 01 EX/MEM ALU result, 10 MEM/WB writeback value.
- mem_err  out  1  one-cycle pulse on memory timeout.
- stall_cycles  out  CNT_W  saturating count of cycles with pc_write=0.

## Operation
- States: RUN, LOAD_STALL, FLUSH, MEM_WAIT. Reset state is RUN.
- Hazard priority, highest first: reset, memory wait, taken branch, load-use.
- Memory wait condition: mem_req && !mem_ready.
  - Go to MEM_WAIT; freeze everything: pc_write=0, ifid_write=0, pipe_hold=1.
  - Stay in MEM_WAIT until mem_ready, then return to RUN.
  - If the wait reaches MEM_TIMEOUT cycles, pulse mem_err and return to RUN.
- Taken branch (branch_taken in RUN or LOAD_STALL):
  - Outputs: ifid_flush=1, idex_bubble=1, pc_write=1.
  - State goes to FLUSH for one cycle, then RUN.
  - A branch overrides a simultaneous load-use stall.
- Load-use condition: ex_memRead && ex_regWrite[0] && ex_dest matches a used source (id_rs1 with id_use1, or id_rs2 with id_use2).
  - Outputs: pc_write=0, ifid_write=0, idex_bubble=1.
  - State goes to LOAD_STALL for exactly one cycle.
  - If the hazard is still present (new ID/EX contents), the stall repeats.
- Defaults in RUN: pc_write=1, ifid_write=1, all other control outputs 0.
- Forwarding (combinational, for each source independently):
  - A producer matches the source if its regWrite[0] is set and its dest equals the source, or if its regWrite[1] is set and the source is 4'h0.
  - An EX/MEM match selects 01. Otherwise a MEM/WB match selects 10. Otherwise select 00.
  - A source with its use flag low selects 00.
- stall_cycles increments on every clock with pc_write=0 and holds at all-ones.

## Timing
- Reset (asynchronous, active-low):
  - State becomes RUN; timeout counter and stall_cycles become 0; mem_err becomes 0.
  - Outputs: pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0, pipe_hold=0, fwdA=fwdB=00.
- Reset asserted mid-MEM_WAIT or mid-stall aborts to RUN immediately, without an mem_err pulse.
- Control outputs are combinational from state and inputs, and must settle within half a cycle. Pipeline registers capture on the falling edge.
- Load-use costs 1 bubble. A taken branch costs 2 squashed slots. A memory wait costs N cycles, where N is the cycles until mem_ready, or MEM_TIMEOUT.
- mem_ready asserted in the same cycle as mem_req causes no stall.
- The timeout counter reloads to 0 on every entry to MEM_WAIT.

## Structure
- A shared package holds:
  - the state encoding (2-bit);
  - the forwarding select constants FWD_RF, FWD_EXMEM, FWD_MEMWB;
  - the regWrite bit positions;
  - the R0 register index constant.
- One natural sub-module, fwd_unit: the purely combinational forwarding comparator, instantiated once per operand.
- The FSM, timeout counter and stall counter stay in hazard_ctrl.

## Test plan
- Load-use: ex_memRead=1, ex_regWrite=01, ex_dest=3, id_rs1=3, id_use1=1 → pc_write=0, ifid_write=0, idex_bubble=1 for 1 cycle; stall_cycles=1.
- Forward priority: mem_dest=5 and wb_dest=5, both regWrite=01, id_rs2=5 → fwdB=01. With mem_regWrite=00 instead → fwdB=10.
- R0 forward: wb_regWrite=10, wb_dest=7, id_rs1=0 → fwdA=10. With id_use1=0 → fwdA=00.
- Branch and load-use together → ifid_flush=1, idex_bubble=1, pc_write=1; FLUSH for one cycle, then RUN.
- Memory wait: mem_req=1 with mem_ready low for 4 cycles → pipe_hold=1 for 4 cycles, then release. mem_ready never asserted → mem_err pulses after 15 cycles.
- Async reset asserted during MEM_WAIT → all outputs at reset values before the next edge. Also: with stall_cycles preloaded to FFFF, a further stall keeps it at FFFF.
